// File: rtl/mux_pkg.sv
// Shared helpers for the round-robin arbitrating mux.
// Index-width and channel-slice arithmetic.
package mux_pkg;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int slice_lo(input int i, input int w);
    return i * w;
  endfunction

endpackage

// File: rtl/rr_mux_n_w_if.sv
// Handshake bundle for the arbitrating mux.
// Producer side and consumer side share one interface.
interface rr_mux_n_w_if
  import mux_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int WIDTH = 16
) ();
  localparam int SELW = idx_w(NCH);

  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_ready;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/rr_mux_n_w_arbiter.sv
// Combinational round-robin / fixed-priority arbiter.
// Search starts at ptr (or 0) and wraps explicitly modulo NCH.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int NCH  = 8,
  localparam int SELW = idx_w(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  input  logic            fix_pri,
  input  logic            en,
  output logic [NCH-1:0]  gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            any_gnt
);
  int   base;
  int   c;
  int   idx;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    found   = 1'b0;
    idx     = 0;
    c       = 0;
    base    = fix_pri ? 0 : int'(ptr);
    for (int k = 0; k < NCH; k++) begin
      c = base + k;
      if (c >= NCH) c = c - NCH;
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
    if (found && en) begin
      gnt[idx] = 1'b1;
      gnt_idx  = SELW'(idx);
      any_gnt  = 1'b1;
    end
  end
endmodule

// File: rtl/rr_mux_n_w.sv
// N-channel W-bit arbitrating mux with one registered output stage.
// Owns the round-robin pointer and the output register.
module rr_mux_n_w
  import mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fix_pri,
  rr_mux_n_w_if.slave  bus
);
  localparam int SELW = idx_w(NCH);

  logic [SELW-1:0] ptr;
  logic [SELW-1:0] gnt_idx;
  logic [NCH-1:0]  gnt;
  logic            any_gnt;
  logic            load_en;
  logic            en;

  assign load_en = !bus.out_valid || bus.out_ready;
  // Gate with rst_n so nothing is accepted while reset is held.
  assign en = load_en && rst_n;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (bus.in_valid),
    .ptr     (ptr),
    .fix_pri (fix_pri),
    .en      (en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign bus.in_ready = gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      ptr           <= '0;
    end else if (any_gnt) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data[slice_lo(int'(gnt_idx), WIDTH) +: WIDTH];
      bus.out_ch    <= gnt_idx;
      if (!fix_pri)
        ptr <= (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (load_en) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/rr_mux_n_w.md
Name: rr_mux_n_w

Overview:
- Parametrised N-channel, W-bit arbitrating multiplexer with valid/ready handshakes on every input and on the output.
- Replaces fixed-select mux trees where several producers share one datapath consumer, e.g. writeback sources or memory request ports.
- Selection is made internally: round-robin, or fixed priority when the mode pin is set.
- One registered output stage gives 1-cycle latency and full throughput.

Parameters:
- WIDTH, 16, data width of each channel.
- NCH, 8, number of input channels; must be >= 2; need not be a power of two.
- SELW, $clog2(NCH), local parameter; width of the channel index. Not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  NCH  per-channel request; bit i belongs to channel i.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NCH  per-channel accept; combinational.
- fix_pri  input  1  0 = round-robin mode; 1 = fixed priority, lowest index wins.
- out_valid  output  1  the output register holds a beat.
- out_data  output  WIDTH  registered data of the held beat.
- out_ch  output  SELW  index of the channel that supplied the held beat.
- out_ready  input  1  consumer accepts the beat this cycle.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0. Any beat in flight is dropped. in_ready is all-zero while rst_n is low.
- load_en = !out_valid || out_ready. This is combinational, which gives full throughput with no bubble.
- Grant, combinational, at most one-hot:
  - Round-robin (fix_pri=0): search channels starting at ptr, then ptr+1, and so on, wrapping modulo NCH. The first channel with in_valid set wins.
  - Fixed priority (fix_pri=1): the lowest-index channel with in_valid set wins. ptr is ignored.
- in_ready[i] = load_en && grant[i]. Non-granted channels always see in_ready=0.
- A transfer occurs on channel g when in_valid[g] && in_ready[g]. At that clock edge:
  - out_data <= in_data[g]; out_ch <= g; out_valid <= 1.
- If load_en is high and no input is valid: out_valid <= 0; out_data and out_ch hold their values.
- If load_en is low: the output register holds, and no grant reaches in_ready.
- Pointer update happens only on a round-robin transfer: ptr <= (g == NCH-1) ? 0 : g+1. Wrap is explicit, so NCH does not need to be a power of two. ptr holds in fixed-priority mode and when there is no transfer.
- Latency: exactly 1 cycle from transfer to out_valid.
- Back-to-back beats: a new beat may load in the same cycle the old beat is consumed (out_valid && out_ready).
- Fairness: in round-robin mode, with all channels continuously valid and out_ready=1, each channel is granted exactly once every NCH cycles.
- Mode change: fix_pri is sampled combinationally every cycle. Switching from 1 to 0 resumes round-robin from the stored ptr.
- Input protocol: producers may drop in_valid without a transfer. The block keeps no per-channel state apart from ptr.
- Stability: out_data and out_ch are stable while out_valid && !out_ready.

Decomposition:
- Shared package, mux_pkg:
  - clog2-safe index-width function.
  - Channel-slice helper function (index i -> bit offset).
- One sub-module, rr_arbiter:
  - Inputs: req[NCH], ptr, fix_pri, en.
  - Outputs: gnt[NCH] one-hot, gnt_idx[SELW], any_gnt.
  - Purely combinational. Rotate, priority-encode, un-rotate.
- The top level owns ptr, the output register and the handshake logic.

Test Plan:
1. Reset and pointer start: assert rst_n=0 mid-stream while out_valid=1 -> out_valid, out_data and out_ch go to 0 immediately. After release, with all channels valid and fix_pri=0, channel 0 is granted first.
2. Round-robin fairness: NCH=8, all in_valid=1, in_data[i]=16'h1000+i, out_ready=1 -> out_ch sequence 0,1,...,7,0 with one beat per cycle and no bubbles.
3. Sparse requests with wrap: only channels 2 and 6 valid, ptr=7 -> grants are 2, 6, 2, 6, and so on.
4. Backpressure: out_ready=0 for 3 cycles with a beat held -> out_data and out_ch stable, in_ready=0 everywhere. When out_ready rises, the held beat is consumed and the next grant loads in the same cycle.
5. Fixed priority: fix_pri=1, channels 1, 3 and 5 valid -> channel 1 is granted every cycle and ptr is unchanged. Then fix_pri=0 -> round-robin resumes from the old ptr.
6. Non-power-of-two configuration: NCH=5, WIDTH=8, all channels valid -> out_ch cycles 0,1,2,3,4,0, and ptr never exceeds 4.
